// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader: channel count, level type and
// saturating arithmetic helpers used by every fade channel.
package led_pkg;

  localparam int unsigned NUM_LEDS   = 8;
  localparam int unsigned LEVEL_BITS = 8;

  typedef logic [LEVEL_BITS-1:0] level_t;

  // Add b to a and clamp at max_v. Levels and steps are far below 2^31,
  // so the 32-bit sum never wraps before the clamp.
  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned max_v);
    int unsigned sum;
    sum = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

  // Subtract b from a, flooring at zero instead of wrapping.
  function automatic int unsigned sat_sub(input int unsigned a,
                                          input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: a brightness level that snaps on (or ramps up when
// LED_PWM_FADER_FADE_IN_EN is defined) while its pattern bit is set and
// decays by DECAY_STEP per fade tick after it clears, plus the PWM compare.
module led_fade_channel #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned DECAY_STEP = 8
`ifdef LED_PWM_FADER_FADE_IN_EN
  , parameter int unsigned RISE_STEP = 32
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_q,
  input  logic                tick,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                pwm_out
);
  import led_pkg::*;

`ifdef LED_PWM_FADER_FADE_IN_EN
  localparam int unsigned MAX = (2 ** PWM_BITS) - 1;
`endif

  // Level register: rise while the pattern bit is set, decay on ticks otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
`ifdef LED_PWM_FADER_FADE_IN_EN
    end else if (bit_q) begin
      if (tick) begin
        level <= PWM_BITS'(sat_add(32'(level), RISE_STEP, MAX));
      end
`else
    end else if (bit_q) begin
      level <= '1;
`endif
    end else if (tick) begin
      level <= PWM_BITS'(sat_sub(32'(level), DECAY_STEP));
    end
  end

  // PWM compare: high while the level exceeds the shared ramp, gated by enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= enable & (level > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: registers the shifter pattern, runs the shared PWM ramp
// and fade-tick divider, and hosts eight fade channels plus level readback.
// Optional ramped fade-in is selected with the LED_PWM_FADER_FADE_IN_EN macro.
module led_pwm_fader #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned FADE_DIV   = CLK_FREQ / 1000,
  parameter int unsigned DECAY_STEP = 8,
  parameter int unsigned RISE_STEP  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          pattern_in,
  input  logic                enable,
  input  logic [2:0]          sel,
  output logic [7:0]          pwm_out,
  output logic [PWM_BITS-1:0] level_out,
  output logic                all_dark
);
  import led_pkg::*;

  localparam int unsigned FADE_W = $clog2(FADE_DIV);

  // Reject configurations whose fade arithmetic would stall or never tick.
  if (FADE_DIV < 2) begin : g_bad_fade_div
    $error("led_pwm_fader: FADE_DIV must be at least 2");
  end
  if (RISE_STEP == 0 || DECAY_STEP == 0) begin : g_bad_step
    $error("led_pwm_fader: RISE_STEP and DECAY_STEP must be non-zero");
  end

  logic [NUM_LEDS-1:0] pattern_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FADE_W-1:0]   fade_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] level [NUM_LEDS];
  logic                any_lit;

  assign tick = (fade_cnt == FADE_W'(FADE_DIV - 1));

  // Pattern capture, free-running PWM ramp and fade-tick divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= '0;
      pwm_cnt   <= '0;
      fade_cnt  <= '0;
    end else begin
      pattern_q <= pattern_in;
      pwm_cnt   <= pwm_cnt + 1'b1;
      fade_cnt  <= tick ? '0 : fade_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
`ifdef LED_PWM_FADER_FADE_IN_EN
      , .RISE_STEP (RISE_STEP)
`endif
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .bit_q   (pattern_q[i]),
      .tick    (tick),
      .enable  (enable),
      .pwm_cnt (pwm_cnt),
      .level   (level[i]),
      .pwm_out (pwm_out[i])
    );
  end

  // Any channel still carrying light.
  always_comb begin
    any_lit = 1'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      any_lit = any_lit | (|level[i]);
    end
  end

  // Registered level readback and all-dark flag, one cycle behind the levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_out <= '0;
      all_dark  <= 1'b1;
    end else begin
      level_out <= level[sel];
      all_dark  <= ~any_lit;
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader: directed scenarios followed by
// randomized pattern/enable/sel traffic, all compared against a cycle-indexed
// reference model of the fade rules.
module tb_led_pwm_fader;

  localparam int PWM_BITS   = 8;
  localparam int FADE_DIV   = 4;
  localparam int DECAY_STEP = 64;
  localparam int RISE_STEP  = 128;
  localparam int MAXL       = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pattern_in;
  logic       enable;
  logic [2:0] sel;
  logic [7:0] pwm_out;
  logic [7:0] level_out;
  logic       all_dark;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: levels as plain integers, edges counted since reset.
  int         m_lvl [8];
  logic [7:0] m_pat_q;
  int         m_k;
  logic [7:0] m_pwm;
  int         m_lvl_out;
  logic       m_dark;

  logic [7:0] exp_q [$];

  // Clock
  always #5 clk = ~clk;

  led_pwm_fader #(
    .CLK_FREQ   (25_000_000),
    .PWM_BITS   (PWM_BITS),
    .FADE_DIV   (FADE_DIV),
    .DECAY_STEP (DECAY_STEP),
    .RISE_STEP  (RISE_STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pattern_in (pattern_in),
    .enable     (enable),
    .sel        (sel),
    .pwm_out    (pwm_out),
    .level_out  (level_out),
    .all_dark   (all_dark)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance the model across the coming edge, clock the DUT, compare outputs.
  task automatic step();
    int pc;
    bit tk;
    if (!rst_n) begin
      foreach (m_lvl[i]) m_lvl[i] = 0;
      m_pat_q   = 8'h00;
      m_k       = 0;
      m_pwm     = 8'h00;
      m_lvl_out = 0;
      m_dark    = 1'b1;
    end else begin
      pc = m_k % 256;
      tk = ((m_k % FADE_DIV) == FADE_DIV - 1);
      m_lvl_out = m_lvl[sel];
      m_dark = 1'b1;
      for (int i = 0; i < 8; i++) begin
        m_pwm[i] = enable && (m_lvl[i] > pc);
        if (m_lvl[i] != 0) m_dark = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (m_pat_q[i]) begin
`ifdef LED_PWM_FADER_FADE_IN_EN
          if (tk) m_lvl[i] = (m_lvl[i] + RISE_STEP > MAXL) ? MAXL : m_lvl[i] + RISE_STEP;
`else
          m_lvl[i] = MAXL;
`endif
        end else if (tk) begin
          m_lvl[i] = (m_lvl[i] > DECAY_STEP) ? m_lvl[i] - DECAY_STEP : 0;
        end
      end
      m_pat_q = pattern_in;
      m_k++;
    end
    @(posedge clk);
    #1;
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("level_out", 32'(level_out), m_lvl_out);
    check("all_dark", 32'(all_dark), 32'(m_dark));
  endtask

  // Step for a number of cycles, matching each level_out change against exp_q.
  task automatic track(input string tag, input int cycles);
    logic [7:0] prev;
    int last_c;
    prev = level_out;
    last_c = -1;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (level_out !== prev) begin
        if (exp_q.size() == 0) check({tag, "_extra"}, 32'(level_out), 32'(prev));
        else check(tag, 32'(level_out), 32'(exp_q.pop_front()));
        if (last_c >= 0) check({tag, "_gap"}, c - last_c, FADE_DIV);
        last_c = c;
        prev = level_out;
      end
    end
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int hi;
    int hold;
    rst_n = 1'b0;
    enable = 1'b1;
    pattern_in = 8'h00;
    sel = 3'd0;

    // Reset held for three cycles
    repeat (3) step();
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_level", 32'(level_out), 0);
    check("rst_dark", 32'(all_dark), 1);
    rst_n = 1'b1;
    repeat (4) step();

`ifdef LED_PWM_FADER_FADE_IN_EN
    // Ramped fade-in on channel 7
    sel = 3'd7;
    pattern_in = 8'h80;
    exp_q = '{8'd128, 8'd255};
    track("fadein", 24);
    check("fadein_hold", 32'(level_out), MAXL);
`else
    // Snap-on on channel 0, then duty over one full PWM period
    sel = 3'd0;
    pattern_in = 8'h01;
    repeat (3) step();
    check("snap_3cyc", 32'(level_out), MAXL);
    hi = 0;
    repeat (256) begin
      step();
      if (pwm_out[0]) hi++;
    end
    check("snap_duty", hi, 255);
`endif

    // Decay from full scale
    pattern_in = 8'h00;
    exp_q = '{8'd191, 8'd127, 8'd63, 8'd0};
    track("decay", 24);
    check("decay_dark", 32'(all_dark), 1);

    // Enable gate with every channel lit
    pattern_in = 8'hFF;
    repeat (12) step();
    check("gate_pre_lvl", 32'(level_out), MAXL);
    enable = 1'b0;
    step();
    check("gate_off_pwm", 32'(pwm_out), 0);
    check("gate_off_lvl", 32'(level_out), MAXL);
    repeat (5) step();
    check("gate_off_hold", 32'(pwm_out), 0);
    enable = 1'b1;
    repeat (4) step();
    check("gate_on_lvl", 32'(level_out), MAXL);

    // Reset in the middle of a decay
    pattern_in = 8'h00;
    for (int c = 0; c < 40 && level_out !== 8'd127; c++) step();
    check("midfade_reach", 32'(level_out), 127);
    rst_n = 1'b0;
    step();
    check("midfade_lvl", 32'(level_out), 0);
    check("midfade_pwm", 32'(pwm_out), 0);
    check("midfade_dark", 32'(all_dark), 1);
    rst_n = 1'b1;

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 900; c++) begin
      if (hold == 0) begin
        pattern_in = 8'($urandom_range(0, 255));
        enable = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 30);
      end
      hold--;
      sel = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream output stage for the 8-bit LED shifter pattern. Takes the shifter's `leds` word and drives the physical LED pins with per-channel PWM. Each LED keeps a brightness level that rises while its pattern bit is set and decays after it clears, so the rotating pattern leaves a fading trail. It sits between the shifter output and the board pins.

## Interface
- `CLK_FREQ`, 25_000_000: clock frequency in Hz; used only to derive the `FADE_DIV` default.
- `PWM_BITS`, 8: width of the level registers and the PWM counter. `MAX` = 2^PWM_BITS−1.
- `FADE_DIV`, CLK_FREQ/1000: clocks per fade tick. Must be ≥ 2.
- `DECAY_STEP`, 8: amount subtracted from a level per tick while its bit is clear.
- `RISE_STEP`, 32: amount added to a level per tick while its bit is set (used only with `FADE_IN_EN`).
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `pattern_in`, in, 8: LED pattern from the shifter. Bit i controls LED i.
- `enable`, in, 1: output gate. Low forces all `pwm_out` bits to 0.
- `sel`, in, 3: level readback channel select.
- `pwm_out`, out, 8: PWM drive to the LED pins, active-high.
- `level_out`, out, PWM_BITS: registered copy of `level[sel]`.
- `all_dark`, out, 1: high when every level is 0.

## Operation
- `pattern_in` is registered into `pattern_q` every cycle. All fade decisions use `pattern_q`.
- `pwm_cnt` is a free-running PWM_BITS counter that wraps MAX→0.
- `fade_cnt` counts 0..FADE_DIV−1 and wraps. `tick` is high for the one cycle in which `fade_cnt == FADE_DIV−1`.
- Per-channel level update:
  - `pattern_q[i]` = 0 and `tick`: `level[i] <= (level[i] > DECAY_STEP) ? level[i] − DECAY_STEP : 0`. This saturates at 0 and never underflows.
  - `pattern_q[i]` = 1: behaviour depends on `FADE_IN_EN` (see Configuration).
  - Saturating add is computed at PWM_BITS+1 width and clamped to MAX.
  - No tick and bit clear: level holds.
- `pwm_out[i] <= enable & (level[i] > pwm_cnt)`.
  - Level 0 gives a permanently dark output.
  - Level MAX gives MAX/2^PWM_BITS duty (255 of 256 cycles at default).
- `enable` gates the output only. Levels and counters keep running while it is low.
- `level_out <= level[sel]`.
- `all_dark <= (all levels == 0)`.
- Simultaneous events:
  - A `pattern_q` change in a tick cycle uses the new `pattern_q` value.
  - All channels update independently in the same cycle.
- Reset values: `pattern_q`=0, all levels 0, `pwm_cnt`=0, `fade_cnt`=0, `pwm_out`=0, `level_out`=0, `all_dark`=1.
- Reset mid-fade: all state returns to the reset values on the next `clk` edge with `rst_n` low. There is no partial state.

## Timing
- `pattern_in` → `pattern_q`: 1 cycle. `pattern_q` → level: 1 cycle when updated. Level → `pwm_out`: 1 cycle.
- Without `FADE_IN_EN`, a rising pattern bit reaches `pwm_out` 3 edges after `pattern_in` is stable, subject to `pwm_cnt < MAX`.
- Decay from MAX to 0 takes ceil(MAX/DECAY_STEP) ticks. At default parameters that is 32 ticks, i.e. 32 ms.
- PWM period: 2^PWM_BITS cycles.
- `level_out` and `all_dark` lag the level registers by 1 cycle.

## Configuration
- Macro: `LED_PWM_FADER_FADE_IN_EN`.
- Defined: while the bit is set, the level rises by RISE_STEP on each tick, saturating at MAX.
- Undefined: while the bit is set, `level[i] <= MAX` every cycle with no tick dependency, so LEDs snap fully on. `RISE_STEP` is ignored.

## Structure
- Shared package `led_pkg`:
  - `NUM_LEDS` = 8.
  - Level typedef, width PWM_BITS.
  - Saturating add/sub functions.
- Sub-module `led_fade_channel`, instantiated 8 times. Each instance holds one level register and its saturating update logic, and does its own PWM compare.
- The top level owns `pattern_q`, `pwm_cnt`, `fade_cnt`/`tick`, the `sel` mux and `all_dark`.

## Test plan
Parameters for all scenarios: FADE_DIV=4, DECAY_STEP=64, RISE_STEP=128, PWM_BITS=8.
- Reset: hold `rst_n`=0 for 3 cycles → `pwm_out`=0, `level_out`=0, `all_dark`=1. Release → `pwm_cnt` counts 0,1,2…
- Snap-on (macro undefined): `pattern_in`=8'h01, `sel`=0 → `level_out`=255 within 3 cycles. `pwm_out[0]` is high 255 of every 256 cycles.
- Decay: from level 255, set `pattern_in`=0 → level goes 191, 127, 63, 0 on successive ticks, 4 cycles apart. `all_dark` rises 1 cycle after level reaches 0.
- Fade-in (macro defined): from level 0, `pattern_in`=8'h80, `sel`=7 → level goes 128, 255 and holds at 255.
- Enable gate: levels at 255, `enable`=0 → `pwm_out`=0 next cycle while `level_out` stays 255. Re-enable → PWM resumes with no level change.
- Reset mid-fade: assert `rst_n`=0 while level=127 → level 0 and `pwm_out`=0 on the next edge.
